// File: rtl/mmu_responder_if.sv
// Request/response channel between the core's data MMU port and the memory responder.
// The package carries the operation encoding shared by both sides.
package mmu_pkg;
  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } MemoryOperation;
endpackage

interface mmu_responder_if;
  import mmu_pkg::*;

  logic           request_ready_out;
  logic           request_valid_in;
  logic [31:0]    request_address_in;
  MemoryOperation request_operation_in;
  logic [31:0]    request_data_in;
  logic           response_ready_in;
  logic           response_valid_out;
  logic [31:0]    response_data_out;

  modport slave (
    output request_ready_out,
    input  request_valid_in,
    input  request_address_in,
    input  request_operation_in,
    input  request_data_in,
    input  response_ready_in,
    output response_valid_out,
    output response_data_out
  );

  modport master (
    input  request_ready_out,
    output request_valid_in,
    output request_address_in,
    output request_operation_in,
    output request_data_in,
    output response_ready_in,
    input  response_valid_out,
    input  response_data_out
  );
endinterface

// File: rtl/mmu_responder.sv
// Word-array backing store for the data MMU port: in-order load responses through a
// fixed-latency read pipeline and a credit-protected show-ahead response FIFO.
module mmu_responder #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  mmu_responder_if.slave bus
);
  import mmu_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] CREDITS   = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(RESP_DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   fifo_mem [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] fifo_count_reg, fifo_count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [AW-1:0] index;
  logic          accept, load_accept, store_accept;
  logic          resp_hs, fifo_push, fifo_empty, fifo_full;
  logic [31:0]   pipe_tail_data;
  logic          unused_addr_bits;

  assign index            = bus.request_address_in[AW+1:2];
  assign unused_addr_bits = ^{bus.request_address_in[31:AW+2], bus.request_address_in[1:0]};

  // Ready depends only on the credit count (and reset), never on this cycle's valid/ready inputs.
  assign bus.request_ready_out = rst_in && (outstanding_reg < CREDITS);
  assign accept       = bus.request_valid_in && bus.request_ready_out;
  assign load_accept  = accept && (bus.request_operation_in == MEM_LOAD);
  assign store_accept = accept && (bus.request_operation_in == MEM_STORE);

  assign fifo_empty             = (fifo_count_reg == '0);
  assign fifo_full              = (fifo_count_reg == CREDITS);
  assign bus.response_valid_out = !fifo_empty;
  assign bus.response_data_out  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
  assign resp_hs                = bus.response_valid_out && bus.response_ready_in;

  for (genvar gi = 0; gi < LATENCY; gi++) begin : stage
    logic        valid_reg;
    logic [31:0] data_reg;

    if (gi == 0) begin : g_head
      // Stage 0 is the registered array read; stores land on the same edge they are accepted.
      always_ff @(posedge clk_in) begin
        if (store_accept) mem[index] <= bus.request_data_in;
        if (load_accept)  data_reg   <= mem[index];
      end

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) valid_reg <= 1'b0;
        else         valid_reg <= load_accept;
      end
    end else begin : g_body
      always_ff @(posedge clk_in) begin
        data_reg <= stage[gi-1].data_reg;
      end

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) valid_reg <= 1'b0;
        else         valid_reg <= stage[gi-1].valid_reg;
      end
    end
  end

  assign fifo_push      = stage[LATENCY-1].valid_reg;
  assign pipe_tail_data = stage[LATENCY-1].data_reg;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    outstanding_next = outstanding_reg;
    if (load_accept && !resp_hs)      outstanding_next = outstanding_reg + CW'(1);
    else if (!load_accept && resp_hs) outstanding_next = outstanding_reg - CW'(1);
  end

  always_comb begin
    fifo_count_next = fifo_count_reg;
    if (fifo_push && !resp_hs)      fifo_count_next = fifo_count_reg + CW'(1);
    else if (!fifo_push && resp_hs) fifo_count_next = fifo_count_reg - CW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= pipe_tail_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fifo_count_reg  <= '0;
      outstanding_reg <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (resp_hs)   rd_ptr_reg <= bump(rd_ptr_reg);
      fifo_count_reg  <= fifo_count_next;
      outstanding_reg <= outstanding_next;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_mmu_responder.sv
// Scoreboard bench for mmu_responder: the driver queues expected load data at acceptance,
// and an independent monitor checks every response handshake against the queue.
module tb_mmu_responder;
  import mmu_pkg::*;

  localparam int DEPTH      = 1024;
  localparam int LATENCY    = 2;
  localparam int RESP_DEPTH = 4;

  typedef struct {
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   resp_cnt = 0;
  exp_t sb[$];

  mmu_responder_if bus();

  mmu_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: every response handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && bus.response_valid_out && bus.response_ready_in) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp got=%h expected=none", bus.response_data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        resp_cnt++;
        if (bus.response_data_out !== e.data) begin
          failures++;
          $display("FAIL resp_data got=%h expected=%h", bus.response_data_out, e.data);
        end else begin
          $display("resp %0d data=%h cyc=%0d", resp_cnt, bus.response_data_out, cyc);
        end
        if (e.exp_cyc >= 0) begin
          checks++;
          if (cyc != e.exp_cyc) begin
            failures++;
            $display("FAIL resp_latency got=cyc%0d expected=cyc%0d", cyc, e.exp_cyc);
          end
        end
      end
    end
  end

  // Entered and left at posedge+1; a load pushes its expectation on acceptance.
  task automatic do_req(input MemoryOperation op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp, input bit exact);
    int waited = 0;
    exp_t e;
    bus.request_valid_in     = 1'b1;
    bus.request_operation_in = op;
    bus.request_address_in   = addr;
    bus.request_data_in      = data;
    @(negedge clk);
    while (!bus.request_ready_out && waited < 50) begin
      waited++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!bus.request_ready_out) begin
      checks++;
      failures++;
      $display("FAIL req_timeout got=ready0 expected=ready1 addr=%h", addr);
      @(posedge clk);
      #1;
      bus.request_valid_in = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.request_valid_in = 1'b0;
      if (op == MEM_LOAD) begin
        e.data    = exp;
        e.exp_cyc = exact ? cyc + LATENCY : -1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.response_ready_in = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d expected=0 pending", sb.size());
    end
  endtask

  initial begin
    bus.request_valid_in     = 1'b0;
    bus.request_address_in   = '0;
    bus.request_operation_in = MEM_LOAD;
    bus.request_data_in      = '0;
    bus.response_ready_in    = 1'b0;

    // Reset state
    #22;
    check("rst_ready", {31'd0, bus.request_ready_out}, 32'd0);
    check("rst_valid", {31'd0, bus.response_valid_out}, 32'd0);
    check("rst_data", bus.response_data_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, bus.request_ready_out}, 32'd1);

    // Store then load the next cycle; byte offset bits ignored
    bus.response_ready_in = 1'b1;
    do_req(MEM_STORE, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(MEM_LOAD,  32'h40, 32'h0, 32'hDEADBEEF, 1'b1);
    do_req(MEM_LOAD,  32'h43, 32'h0, 32'hDEADBEEF, 1'b1);
    drain();

    // Address wrap modulo 4*DEPTH
    do_req(MEM_STORE, 32'h1008, 32'h00001234, 32'h0, 1'b0);
    do_req(MEM_LOAD,  32'h8, 32'h0, 32'h00001234, 1'b1);
    drain();

    // Backpressure: only RESP_DEPTH loads accepted
    for (int i = 1; i <= 6; i++) do_req(MEM_STORE, 32'h100 + 32'(4 * i), 32'(i), 32'h0, 1'b0);
    bus.response_ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) do_req(MEM_LOAD, 32'h100 + 32'(4 * i), 32'h0, 32'(i), 1'b0);
    @(negedge clk);
    check("bp_ready_drop", {31'd0, bus.request_ready_out}, 32'd0);
    bus.request_valid_in     = 1'b1;
    bus.request_operation_in = MEM_LOAD;
    bus.request_address_in   = 32'h114;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_held_low", {31'd0, bus.request_ready_out}, 32'd0);
    end
    @(posedge clk); #1;
    bus.request_valid_in  = 1'b0;
    bus.response_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_reassert", {31'd0, bus.request_ready_out}, 32'd1);
    @(posedge clk); #1;
    do_req(MEM_LOAD, 32'h114, 32'h0, 32'd5, 1'b0);
    do_req(MEM_LOAD, 32'h118, 32'h0, 32'd6, 1'b0);
    drain();

    // Streaming: 16 back-to-back loads, exact latency each
    for (int i = 0; i < 16; i++) do_req(MEM_STORE, 32'h200 + 32'(4 * i), 32'hA5000000 + 32'(i), 32'h0, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) do_req(MEM_LOAD, 32'h200 + 32'(4 * i), 32'h0, 32'hA5000000 + 32'(i), 1'b1);
    check("stream_no_stall", 32'(stall_cnt), 32'd0);
    drain();

    // Load accepted in the same cycle as a handshake at outstanding=3
    bus.response_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) do_req(MEM_LOAD, 32'h200 + 32'(4 * i), 32'h0, 32'hA5000000 + 32'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.response_ready_in = 1'b1;
    do_req(MEM_LOAD, 32'h20C, 32'h0, 32'hA5000003, 1'b0);
    bus.response_ready_in = 1'b0;
    @(negedge clk);
    check("sim_ready_held", {31'd0, bus.request_ready_out}, 32'd1);
    @(posedge clk); #1;
    do_req(MEM_LOAD, 32'h210, 32'h0, 32'hA5000004, 1'b0);
    @(negedge clk);
    check("sim_count_kept", {31'd0, bus.request_ready_out}, 32'd0);
    @(posedge clk); #1;
    drain();

    // Reset with loads outstanding
    bus.response_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) do_req(MEM_LOAD, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, bus.response_valid_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.response_valid_out}, 32'd0);
    check("mid_rst_data", bus.response_data_out, 32'd0);
    check("mid_rst_ready", {31'd0, bus.request_ready_out}, 32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.response_ready_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_stale", {31'd0, bus.response_valid_out}, 32'd0);
    do_req(MEM_LOAD, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1);
    do_req(MEM_LOAD, 32'h8,  32'h0, 32'h00001234, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
